mcp_mem_iface: RTL
==================

// Module: mcp_mem_iface
// PURPOSE
//  Multicycle-processor memory port between the controller FSM/datapath and a shared instr/data memory.
//  Muxes address by IorD and issues one request/ack bus transaction per memory state.
//  Latches read data into the Instruction Register (IRWrite) or the Data register and feeds op back to the FSM.
//  Asserts stall_o so the controller holds its current state until the transaction completes.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width (IR and Data register width)
//  TIMEOUT  16  max WAIT cycles without ack before abort; >=2
// PORTS
//  clk_i            in   1   clock, all state updates on posedge
//  reset_ni         in   1   reset, asynchronous, active-low
//  rd_req_i         in   1   controller requests a memory read (FETCH, MEM_READ)
//  enable_wmem_i    in   1   controller requests a memory write (MEM_WRITE)
//  instr_or_data_i  in   1   IorD: 0 = address from pc_i, 1 = address from alu_out_i
//  instr_we_i       in   1   IRWrite: read data goes to IR (1) or Data register (0)
//  pc_i             in   AW  program counter
//  alu_out_i        in   AW  ALUOut register (lw/sw address)
//  wdata_i          in   DW  B register (sw data)
//  mem_req_o        out  1   bus request, held until ack or timeout
//  mem_we_o         out  1   bus write strobe, valid with mem_req_o
//  mem_addr_o       out  AW  bus address, stable while mem_req_o
//  mem_wdata_o      out  DW  bus write data, stable while mem_req_o
//  mem_rdata_i      in   DW  bus read data, sampled on ack
//  mem_ack_i        in   1   bus completion, one-cycle pulse
//  instr_o          out  DW  Instruction Register
//  op_o             out  6   instr_o[31:26], opcode to controller
//  data_o           out  DW  Data register (lw result)
//  stall_o          out  1   controller must not advance state while high
//  err_o            out  1   sticky: a transaction timed out
// BEHAVIOUR
//  Reset: state=IDLE. mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, instr_o, data_o, err_o = 0. stall_o = 0.
//  Reset mid-transaction: mem_req_o drops asynchronously, with no IR/Data update.
//  FSM: IDLE -> WAIT -> DONE -> IDLE.
//  IDLE:
//   - Request (rd_req_i|enable_wmem_i): capture addr, we=enable_wmem_i, wdata, dest=instr_we_i; set mem_req_o; ->WAIT.
//   - Captured addr = instr_or_data_i ? alu_out_i : pc_i.
//   - stall_o is combinational: 1 in IDLE when a request is present.
//  WAIT:
//   - stall_o=1; timeout counter increments each cycle.
//   - mem_ack_i=1: clear mem_req_o/mem_we_o. On reads, load mem_rdata_i into IR (dest=1) or Data (dest=0). ->DONE.
//   - Counter reaches TIMEOUT-1 with no ack: clear mem_req_o, set err_o, no register update, ->DONE.
//   - Ack and timeout in the same cycle: ack wins.
//  DONE:
//   - stall_o=0; the controller advances on this edge.
//   - The request still present from the old controller state is ignored. ->IDLE unconditionally.
//  Latency: ack in the first WAIT cycle gives 3 cycles per memory state (IDLE, WAIT, DONE); each wait cycle adds 1.
//  Writes never modify IR or Data. IR and Data hold their values between transactions.
//  rd_req_i and enable_wmem_i both high: treated as a write.
//  mem_ack_i outside WAIT is ignored.
//  mem_addr_o and mem_wdata_o are registered; they do not follow inputs during WAIT.
//  err_o clears only on reset.
// TESTING
//  1. Fetch, pc_i=0x40, IorD=0, IRWrite=1, mem_rdata=0x8C220004, ack in 1st WAIT cycle
//     -> mem_addr_o=0x40; instr_o=0x8C220004 and op_o=0x23 in DONE; stall_o 1,1,0.
//  2. lw, alu_out_i=0x100, IorD=1, IRWrite=0, ack after 3 wait cycles, rdata=0xDEADBEEF
//     -> data_o=0xDEADBEEF, instr_o unchanged, stall_o high 4 cycles then 0.
//  3. sw, enable_wmem_i=1, alu_out_i=0x104, wdata_i=0x12345678
//     -> mem_we_o=1, mem_wdata_o=0x12345678 until ack; IR and Data unchanged.
//  4. No ack for TIMEOUT=16 WAIT cycles -> mem_req_o drops, err_o=1 (sticky), DONE reached, registers unchanged.
//  5. reset_ni low during WAIT -> mem_req_o=0 immediately, all outputs 0; a late ack after release is ignored.
//  6. Request held through DONE, then a new request -> only one bus transaction per request;
//     the second starts in the next IDLE cycle.

Source files
------------

// File: rtl/mcp_mem_iface.sv
// Memory port for a multicycle processor: muxes IorD address, runs one req/ack bus transaction per memory state, loads IR or Data.
// Latency: IDLE, WAIT (one or more cycles, up to TIMEOUT), DONE. stall_o holds the controller until DONE.
module mcp_mem_iface #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          rd_req_i,
  input  logic          enable_wmem_i,
  input  logic          instr_or_data_i,
  input  logic          instr_we_i,
  input  logic [AW-1:0] pc_i,
  input  logic [AW-1:0] alu_out_i,
  input  logic [DW-1:0] wdata_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic [DW-1:0] instr_o,
  output logic [5:0]    op_o,
  output logic [DW-1:0] data_o,
  output logic          stall_o,
  output logic          err_o
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic          dest_q, dest_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    dest_d  = dest_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    data_d  = data_q;
    stall_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rd_req_i || enable_wmem_i) begin
          stall_o = 1'b1;
          addr_d  = instr_or_data_i ? alu_out_i : pc_i;
          we_d    = enable_wmem_i;
          wdata_d = wdata_i;
          dest_d  = instr_we_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        // An ack on the last allowed cycle still completes the transaction.
        if (mem_ack_i) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
          if (!we_q) begin
            if (dest_q) instr_d = mem_rdata_i;
            else        data_d  = mem_rdata_i;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Request from the controller's previous state is still visible here; ignore it.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      dest_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      dest_q  <= dest_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      data_q  <= data_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign instr_o     = instr_q;
  assign op_o        = instr_q[31:26];
  assign data_o      = data_q;
  assign err_o       = err_q;

endmodule
